// File: rtl/frog_move_if.sv
// Keycode/frame inputs and hop command outputs between the keycode PIO side and
// the frog position/animation logic.
interface frog_move_if;
  logic [15:0] keycode;
  logic        frame_clk;
  logic        enable;
  logic        hop_valid;
  logic [1:0]  hop_dir;
  logic        busy;
  logic [7:0]  hop_count;

  modport master (
    output keycode, frame_clk, enable,
    input  hop_valid, hop_dir, busy, hop_count
  );

  modport slave (
    input  keycode, frame_clk, enable,
    output hop_valid, hop_dir, busy, hop_count
  );
endinterface

// File: rtl/frog_move_ctrl.sv
// Turns held USB keycodes into frame-synchronous single-hop commands for the frog:
// one hop per press, a lockout while the hop animates, then auto-repeat while held.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a frame tick with a mapped key pressed
// HOP   | single cycle in which hop_valid is high
// LOCK  | hop animating; key changes ignored until HOP_FRAMES ticks pass
// HOLD  | same key still held; auto-repeat after REPEAT_FRAMES ticks
module frog_move_ctrl #(
  parameter int HOP_FRAMES    = 4,
  parameter int REPEAT_FRAMES = 12,
  parameter int CNT_W         = 5
) (
  input  logic      Clk,
  input  logic      Reset_n,
  frog_move_if.slave mv
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOP  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [CNT_W-1:0] HOP_LD = CNT_W'(HOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] REP_LD = CNT_W'(REPEAT_FRAMES - 1);

  logic [2:0]       fs_q;
  logic             tick_q;
  logic [15:0]      kc_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       lat_dir_q, lat_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hop_valid_q;
  logic [1:0]       hop_dir_q;
  logic [7:0]       hop_count_q;

  logic             hop_now;
  logic [2:0]       dec0, dec1;
  logic             cur_valid;
  logic [1:0]       cur_dir;

  // Returns {valid, dir}
  function automatic logic [2:0] decode_byte(input logic [7:0] b);
    logic [2:0] r;
    r = 3'b000;
    case (b)
      8'h1A, 8'h52: r = 3'b100;
      8'h16, 8'h51: r = 3'b101;
      8'h04, 8'h50: r = 3'b110;
      8'h07, 8'h4F: r = 3'b111;
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

  always_comb begin
    dec0      = decode_byte(kc_q[7:0]);
    dec1      = decode_byte(kc_q[15:8]);
    cur_valid = dec0[2] | dec1[2];
    cur_dir   = dec0[2] ? dec0[1:0] : dec1[1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_dir_d = lat_dir_q;
    hop_now   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q && cur_valid) begin
          state_d   = S_HOP;
          lat_dir_d = cur_dir;
          hop_now   = 1'b1;
        end
      end
      S_HOP: begin
        state_d = S_LOCK;
        cnt_d   = HOP_LD;
      end
      S_LOCK: begin
        if (tick_q) begin
          if (cnt_q == '0) begin
            if (cur_valid && (cur_dir == lat_dir_q)) begin
              state_d = S_HOLD;
              cnt_d   = REP_LD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (tick_q) begin
          if (!cur_valid || (cur_dir != lat_dir_q)) begin
            state_d = S_IDLE;
          end else if (cnt_q == '0) begin
            state_d = S_HOP;
            hop_now = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable overrides everything, including a tick in the same cycle
    if (!mv.enable) begin
      state_d = S_IDLE;
      hop_now = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_q        <= '0;
      tick_q      <= 1'b0;
      kc_q        <= '0;
      state_q     <= S_IDLE;
      lat_dir_q   <= '0;
      cnt_q       <= '0;
      hop_valid_q <= 1'b0;
      hop_dir_q   <= '0;
      hop_count_q <= '0;
    end else begin
      fs_q        <= {fs_q[1:0], mv.frame_clk};
      tick_q      <= fs_q[1] & ~fs_q[2];
      kc_q        <= mv.keycode;
      state_q     <= state_d;
      lat_dir_q   <= lat_dir_d;
      cnt_q       <= cnt_d;
      hop_valid_q <= hop_now;
      if (hop_now) begin
        hop_dir_q   <= lat_dir_d;
        hop_count_q <= hop_count_q + 8'd1;
      end
    end
  end

  assign mv.hop_valid = hop_valid_q;
  assign mv.hop_dir   = hop_dir_q;
  assign mv.busy      = (state_q != S_IDLE);
  assign mv.hop_count = hop_count_q;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Randomised and directed frame-level stimulus for frog_move_ctrl; expected hops
// come from a frame-count reference model and are checked by a scoreboard monitor.
module tb_frog_move_ctrl;
  localparam int HOP = 4;
  localparam int REP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frog_move_if ifc ();

  frog_move_ctrl #(.HOP_FRAMES(HOP), .REPEAT_FRAMES(REP), .CNT_W(5)) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .mv     (ifc)
  );

  typedef struct {
    logic [1:0] dir;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  // Reference model: hop history measured in frames
  bit m_active = 0;
  int m_hop_frame = 0;
  int m_dir = 0;
  int m_count = 0;
  int fn = 0;

  function automatic int byte_dir(input logic [7:0] b);
    case (b)
      8'h1A, 8'h52: return 0;
      8'h16, 8'h51: return 1;
      8'h04, 8'h50: return 2;
      8'h07, 8'h4F: return 3;
      default:      return -1;
    endcase
  endfunction

  function automatic int key_dir(input logic [15:0] kc);
    int d0;
    d0 = byte_dir(kc[7:0]);
    return (d0 >= 0) ? d0 : byte_dir(kc[15:8]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic do_hop(input int d, input int rise_cyc);
    exp_t e;
    m_active    = 1;
    m_hop_frame = fn;
    m_dir       = d;
    m_count     = (m_count + 1) % 256;
    e.dir = 2'(d);
    e.cnt = 8'(m_count);
    e.cyc = rise_cyc + 4;
    sbq.push_back(e);
  endtask

  task automatic model_tick(input logic [15:0] kc, input bit en, input int rise_cyc);
    int d;
    int age;
    d = key_dir(kc);
    fn++;
    if (!en) begin
      m_active = 0;
    end else if (!m_active) begin
      if (d >= 0) do_hop(d, rise_cyc);
    end else begin
      age = fn - m_hop_frame;
      if (age >= HOP) begin
        if (d != m_dir) m_active = 0;
        else if (age == HOP + REP) do_hop(m_dir, rise_cyc);
      end
    end
  endtask

  task automatic check_mid();
    exp_t e;
    chk("busy_mid_frame", {31'd0, ifc.busy}, {31'd0, m_active});
    chk("hop_count_mid_frame", {24'd0, ifc.hop_count}, 32'(m_count));
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_hop actual=none expected dir=%0d count=%0d at cycle %0d", e.dir, e.cnt, e.cyc);
    end
  endtask

  // One frame: stimulus applied mid-frame, frame_clk rises, model evaluates the tick
  task automatic frame(input logic [15:0] kc, input bit en, input bit drop);
    check_mid();
    ifc.keycode = kc;
    ifc.enable  = en;
    repeat (50) @(negedge clk);
    ifc.frame_clk = 1'b1;
    model_tick(kc, en && !drop, cyc);
    if (drop) begin
      repeat (2) @(negedge clk);
      ifc.enable = 1'b0;
      @(negedge clk);
      chk("busy_after_enable_drop", {31'd0, ifc.busy}, 32'd0);
      repeat (47) @(negedge clk);
    end else begin
      repeat (50) @(negedge clk);
    end
    ifc.frame_clk = 1'b0;
  endtask

  task automatic reset_in_hop(input logic [15:0] kc);
    int k;
    check_mid();
    ifc.keycode = kc;
    ifc.enable  = 1'b1;
    repeat (50) @(negedge clk);
    ifc.frame_clk = 1'b1;
    model_tick(kc, 1'b1, cyc);
    k = 0;
    while (!ifc.hop_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!ifc.hop_valid) begin
      tests++;
      fails++;
      $display("FAIL reset_hop_wait actual=no hop expected=hop within 10 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_hop_valid", {31'd0, ifc.hop_valid}, 32'd0);
    chk("async_reset_busy", {31'd0, ifc.busy}, 32'd0);
    chk("async_reset_hop_count", {24'd0, ifc.hop_count}, 32'd0);
    m_active = 0;
    m_count  = 0;
    sbq.delete();
    repeat (40) @(negedge clk);
    ifc.frame_clk = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 10))
      0: return 8'h00;
      1: return 8'h1A;
      2: return 8'h52;
      3: return 8'h16;
      4: return 8'h51;
      5: return 8'h04;
      6: return 8'h50;
      7: return 8'h07;
      8: return 8'h4F;
      9: return 8'h29;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard monitor
  logic [1:0] last_dir = 2'd0;
  bit         prev_v = 0;
  exp_t       me;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_dir = 2'd0;
      prev_v   = 0;
    end else begin
      if (ifc.hop_valid) begin
        tests++;
        if (prev_v) begin
          fails++;
          $display("FAIL hop_valid_back_to_back actual=1 expected=0 (cycle %0d)", cyc);
        end else if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_hop actual dir=%0d count=%0d expected=no hop (cycle %0d)",
                   ifc.hop_dir, ifc.hop_count, cyc);
        end else begin
          me = sbq.pop_front();
          if (ifc.hop_dir !== me.dir || ifc.hop_count !== me.cnt || cyc != me.cyc || ifc.busy !== 1'b1) begin
            fails++;
            $display("FAIL hop_check actual dir=%0d count=%0d cycle=%0d busy=%0d expected dir=%0d count=%0d cycle=%0d busy=1",
                     ifc.hop_dir, ifc.hop_count, cyc, ifc.busy, me.dir, me.cnt, me.cyc);
          end
        end
        last_dir = ifc.hop_dir;
      end else begin
        tests++;
        if (ifc.hop_dir !== last_dir) begin
          fails++;
          $display("FAIL hop_dir_stable actual=%0d expected=%0d (cycle %0d)", ifc.hop_dir, last_dir, cyc);
        end
      end
      prev_v = ifc.hop_valid;
    end
  end

  initial begin
    int run;
    logic [15:0] kc;
    bit en;
    bit drop;
    ifc.keycode   = 16'h0000;
    ifc.frame_clk = 1'b0;
    ifc.enable    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hop_valid", {31'd0, ifc.hop_valid}, 32'd0);
    chk("reset_hop_dir", {30'd0, ifc.hop_dir}, 32'd0);
    chk("reset_busy", {31'd0, ifc.busy}, 32'd0);
    chk("reset_hop_count", {24'd0, ifc.hop_count}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single press
    repeat (2) frame(16'h001A, 1'b1, 1'b0);
    repeat (6) frame(16'h0000, 1'b1, 1'b0);
    // Held key auto-repeat
    repeat (30) frame(16'h0050, 1'b1, 1'b0);
    repeat (3) frame(16'h0000, 1'b1, 1'b0);
    // Slot priority, then direction change
    frame(16'h0752, 1'b1, 1'b0);
    repeat (8) frame(16'h0700, 1'b1, 1'b0);
    repeat (2) frame(16'h0000, 1'b1, 1'b0);
    // Release and re-press inside lockout
    frame(16'h0016, 1'b1, 1'b0);
    frame(16'h0000, 1'b1, 1'b0);
    repeat (2) frame(16'h0016, 1'b1, 1'b0);
    repeat (3) frame(16'h0000, 1'b1, 1'b0);
    // Enable dropped just before the repeat tick
    repeat (12) frame(16'h004F, 1'b1, 1'b0);
    frame(16'h004F, 1'b1, 1'b1);
    frame(16'h004F, 1'b1, 1'b0);
    repeat (6) frame(16'h0000, 1'b1, 1'b0);
    // Reset during the hop cycle, then an unmapped key
    reset_in_hop(16'h001A);
    repeat (5) frame(16'h0029, 1'b1, 1'b0);

    // Randomised runs of held keys
    for (int i = 0; i < 12; i++) begin
      kc  = {($urandom_range(0, 2) == 0) ? pick_key() : 8'h00, pick_key()};
      run = $urandom_range(1, 16);
      for (int j = 0; j < run; j++) begin
        en   = ($urandom_range(0, 9) != 0);
        drop = en && ($urandom_range(0, 14) == 0);
        frame(kc, en, drop);
      end
    end

    repeat (3) frame(16'h0000, 1'b1, 1'b0);
    check_mid();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
